// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multi-cycle MULT/DIV units: starts one op at a time,
// waits out the unit latency, then loads the architectural HI/LO registers.
module muldiv_ctrl #(
  parameter int MULT_LAT = 36,
  parameter int DIV_LAT  = 36,
  parameter int CW       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_mult,
  input  logic        op_div,
  input  logic        divisor_zero,
  input  logic        abort,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        mult_init,
  output logic        mult_stop,
  output logic        div_init,
  output logic        div_stop,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div0
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN_M = 2'd1;
  localparam logic [1:0] RUN_D = 2'd2;

  localparam logic [CW-1:0] ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] M_LOAD = CW'(MULT_LAT);
  localparam logic [CW-1:0] D_LOAD = CW'(DIV_LAT);

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mult_init <= 1'b0;
      mult_stop <= 1'b0;
      div_init  <= 1'b0;
      div_stop  <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div0      <= 1'b0;
    end else begin
      mult_init <= 1'b0;
      mult_stop <= 1'b0;
      div_init  <= 1'b0;
      div_stop  <= 1'b0;
      done      <= 1'b0;
      div0      <= 1'b0;
      case (state)
        IDLE: begin
          // abort squashes any request presented in the same cycle
          if (!abort) begin
            if (op_mult) begin
              state     <= RUN_M;
              mult_init <= 1'b1;
              busy      <= 1'b1;
              cnt       <= M_LOAD;
            end else if (op_div) begin
              if (divisor_zero) begin
                div0 <= 1'b1;
              end else begin
                state    <= RUN_D;
                div_init <= 1'b1;
                busy     <= 1'b1;
                cnt      <= D_LOAD;
              end
            end
          end
        end
        RUN_M, RUN_D: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            if (state == RUN_M) mult_stop <= 1'b1;
            else                div_stop  <= 1'b1;
          end else if (cnt == ONE) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            if (state == RUN_M) begin
              hi_out <= mult_hi;
              lo_out <= mult_lo;
            end else begin
              hi_out <= div_hi;
              lo_out <= div_lo;
            end
          end else if (!(mult_init || div_init)) begin
            // latency is counted from the edge where the unit samples init
            cnt <= cnt - ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a cycle-level reference model and literal spot checks.
module tb_muldiv_ctrl;
  localparam int LAT = 36;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_mult = 1'b0, op_div = 1'b0, divisor_zero = 1'b0, abort = 1'b0;
  logic [31:0] mult_hi = '0, mult_lo = '0, div_hi = '0, div_lo = '0;
  logic        mult_init, mult_stop, div_init, div_stop, busy, done, div0;
  logic [31:0] hi_out, lo_out;

  muldiv_ctrl #(.MULT_LAT(LAT), .DIV_LAT(LAT), .CW(6)) dut (
    .clk(clk), .rst(rst), .op_mult(op_mult), .op_div(op_div),
    .divisor_zero(divisor_zero), .abort(abort),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
    .mult_init(mult_init), .mult_stop(mult_stop), .div_init(div_init), .div_stop(div_stop),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an op in flight is just "which unit" plus edges left until done.
  int          m_op = 0;  // 0 none, 1 mult, 2 div
  int          m_rem = 0;
  bit          started = 0;
  logic        e_mi = 0, e_ms = 0, e_di = 0, e_ds = 0, e_busy = 0, e_done = 0, e_div0 = 0;
  logic [31:0] e_hi = '0, e_lo = '0;

  always @(posedge clk) begin
    started = 1;
    e_mi = 0; e_ms = 0; e_di = 0; e_ds = 0; e_done = 0; e_div0 = 0;
    if (rst) begin
      m_op = 0; e_busy = 0; e_hi = '0; e_lo = '0;
    end else if (m_op == 0) begin
      if (!abort && op_mult) begin
        m_op = 1; m_rem = LAT + 1; e_mi = 1; e_busy = 1;
      end else if (!abort && op_div) begin
        if (divisor_zero) e_div0 = 1;
        else begin m_op = 2; m_rem = LAT + 1; e_di = 1; e_busy = 1; end
      end
    end else begin
      m_rem--;
      if (abort) begin
        if (m_op == 1) e_ms = 1; else e_ds = 1;
        m_op = 0; e_busy = 0;
      end else if (m_rem == 0) begin
        e_hi = (m_op == 1) ? mult_hi : div_hi;
        e_lo = (m_op == 1) ? mult_lo : div_lo;
        m_op = 0; e_busy = 0; e_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("mult_init", mult_init, e_mi);
      chk("mult_stop", mult_stop, e_ms);
      chk("div_init", div_init, e_di);
      chk("div_stop", div_stop, e_ds);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("div0", div0, e_div0);
      chk("hi_out", hi_out, e_hi);
      chk("lo_out", lo_out, e_lo);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits up to maxc negedges for done; n = negedges seen, b = negedges with busy high.
  task automatic wait_done(input int maxc, output int n, output int b, output bit ok);
    n = 0; b = 0; ok = 0;
    while (n < maxc && !ok) begin
      @(negedge clk);
      n++;
      if (busy) b++;
      if (done) ok = 1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL wait_done: no done within %0d cycles", maxc); end
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  int  n, b, inits, dones;
  bit  ok;

  initial begin
    // reset
    idle(3);
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi_out, 0);
    rst = 1'b0;
    idle(2);
    chk("idle_busy", busy, 0);

    // MULT: one-cycle request, 37 busy cycles, capture 1 / FFFF_FFFE
    mult_hi = 32'h1; mult_lo = 32'hFFFF_FFFE;
    op_mult = 1'b1;
    @(negedge clk);
    op_mult = 1'b0;
    chk("mult_init_pulse", mult_init, 1);
    inits = 1; b = 0;
    n = 0; ok = 0;
    wait_done(100, n, b, ok);
    chk("mult_busy_cycles", b + 1, 37);
    chk("mult_done_edge", n + 1, 38);
    chk("mult_hi_cap", hi_out, 32'h1);
    chk("mult_lo_cap", lo_out, 32'hFFFF_FFFE);

    // DIV by zero rejected
    idle(2);
    op_div = 1'b1; divisor_zero = 1'b1;
    @(negedge clk);
    op_div = 1'b0; divisor_zero = 1'b0;
    chk("div0_pulse", div0, 1);
    chk("div0_no_init", div_init, 0);
    chk("div0_busy", busy, 0);
    chk("div0_hi_held", hi_out, 32'h1);
    @(negedge clk);
    chk("div0_one_cycle", div0, 0);

    // priority, then DIV held through RUN_M is accepted right after done
    mult_hi = 32'h1234_5678; mult_lo = 32'h9ABC_DEF0;
    div_hi = 32'h7; div_lo = 32'h3;
    op_mult = 1'b1; op_div = 1'b1;
    @(negedge clk);
    op_mult = 1'b0;
    chk("prio_mult_init", mult_init, 1);
    chk("prio_no_div_init", div_init, 0);
    wait_done(100, n, b, ok);
    chk("b2b_mult_hi", hi_out, 32'h1234_5678);
    @(negedge clk);
    chk("b2b_div_init", div_init, 1);
    op_div = 1'b0;
    mult_hi = 32'hDEAD_BEEF;
    wait_done(100, n, b, ok);
    chk("b2b_div_busy", b + 1, 37);
    chk("b2b_div_hi", hi_out, 32'h7);
    chk("b2b_div_lo", lo_out, 32'h3);

    // abort mid RUN_D (28 edges after accept)
    idle(1);
    div_hi = 32'hAA; div_lo = 32'hBB;
    op_div = 1'b1;
    @(negedge clk);
    op_div = 1'b0;
    idle(27);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_div_stop", div_stop, 1);
    chk("abort_busy", busy, 0);
    dones = 0;
    repeat (15) begin @(negedge clk); if (done) dones++; end
    chk("abort_no_done", dones, 0);
    chk("abort_hi_held", hi_out, 32'h7);

    // abort exactly on the completion edge
    mult_hi = 32'h55; mult_lo = 32'h66;
    op_mult = 1'b1;
    @(negedge clk);
    op_mult = 1'b0;
    idle(36);
    chk("late_abort_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("late_abort_no_done", done, 0);
    chk("late_abort_stop", mult_stop, 1);
    chk("late_abort_hi", hi_out, 32'h7);
    chk("late_abort_lo", lo_out, 32'h3);

    // abort in IDLE squashes a request
    op_mult = 1'b1; abort = 1'b1;
    @(negedge clk);
    op_mult = 1'b0; abort = 1'b0;
    chk("idle_abort_no_init", mult_init, 0);
    chk("idle_abort_busy", busy, 0);

    // reset mid RUN_M
    op_mult = 1'b1;
    @(negedge clk);
    op_mult = 1'b0;
    idle(10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_hi", hi_out, 0);
    chk("midrst_lo", lo_out, 0);
    dones = 0;
    repeat (40) begin @(negedge clk); if (done) dones++; end
    chk("midrst_no_done", dones, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
